apb_master_bridge: RTL and testbench

- APB requester (master) that drives the APB slave register files generated by the autoregfile flow.
- Accepts one read or write command at a time on a valid/ready command port and runs the standard APB SETUP→ACCESS sequence, honouring pready wait states and pslverr.
- Returns read data and error status on a valid/ready response port.
- A programmable watchdog aborts transfers whose slave never asserts pready.

---
 rtl/apb_master_pkg.sv | 15 +
 rtl/apb_master_bridge_watchdog.sv | 30 +++
 rtl/apb_master_bridge.sv | 102 ++++++++++
 tb/tb_apb_master_bridge.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB requester bridge.
package apb_master_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_SLVERR  = 2'd1;
  localparam logic [1:0] RSP_TIMEOUT = 2'd2;

  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 256;
  localparam int DEF_CNT_WIDTH      = 16;

endpackage

// File: rtl/apb_master_bridge_watchdog.sv
// Counts stalled ACCESS cycles; expire fires in the last allowed stalled cycle.
module apb_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_ok;
      assign unused_ok = ^{clk, rst, enable, clear};
      assign expire    = 1'b0;
    end else begin : g_on
      logic [CNT_WIDTH-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else if (enable)  cnt <= cnt + 1'b1;
      end

      assign expire = enable && (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: command in, SETUP/ACCESS on APB, response out.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  state_t state;
  logic   wd_expire;

  assign cmd_ready = (state == IDLE);

  apb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_wd (
    .clk   (clk),
    .rst   (rst),
    .enable((state == ACCESS) && !pready),
    .clear ((state == RESP) && rsp_ready),
    .expire(wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          paddr  <= cmd_addr;
          pwrite <= cmd_write;
          pwdata <= cmd_write ? cmd_wdata : '0;
          psel   <= 1'b1;
          state  <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a watchdog expiry in the same cycle
          if (pready) begin
            rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= RESP;
          end else if (wd_expire) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a 4-cycle watchdog.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [7:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_pass   = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    step();
    cmd_valid = 1'b0; cmd_addr = 8'hEE; cmd_wdata = 32'h0BAD_F00D;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_checks++; if ({psel, penable, pwrite} !== 3'b000) $display("FAIL reset_apb: got %b exp 000", {psel, penable, pwrite}); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000) $display("FAIL reset_rsp: got %b exp 000", {rsp_valid, rsp_err, rsp_timeout}); else n_pass++;
    n_checks++; if ({paddr, pwdata, rsp_rdata} !== 72'h0) $display("FAIL reset_data: got %h exp 0", {paddr, pwdata, rsp_rdata}); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_zero_wait_write();
    pready = 1'b1;
    issue(1'b1, 8'h04, 32'hDEADBEEF);
    n_checks++; if ({psel, penable, cmd_ready} !== 3'b100) $display("FAIL zw_setup: got %b exp 100", {psel, penable, cmd_ready}); else n_pass++;
    step();
    n_checks++; if ({psel, penable, pwrite} !== 3'b111) $display("FAIL zw_access_ctl: got %b exp 111", {psel, penable, pwrite}); else n_pass++;
    n_checks++; if ({paddr, pwdata} !== {8'h04, 32'hDEADBEEF}) $display("FAIL zw_access_data: got %h exp 04deadbeef", {paddr, pwdata}); else n_pass++;
    step();
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout, psel, penable} !== 5'b10000) $display("FAIL zw_rsp_flags: got %b exp 10000", {rsp_valid, rsp_err, rsp_timeout, psel, penable}); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL zw_rsp_rdata: got %h exp 0", rsp_rdata); else n_pass++;
    step();
    n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL zw_return_idle: got %b exp 01", {rsp_valid, cmd_ready}); else n_pass++;
  endtask

  // Three stalled ACCESS cycles, pready on the 4th: also the watchdog's last cycle.
  task automatic test_wait_read();
    pready = 1'b0; prdata = 32'hCAFE_0000;
    issue(1'b0, 8'h08, 32'h1111_1111);
    n_checks++; if (pwdata !== 32'h0) $display("FAIL wr_read_pwdata: got %h exp 0", pwdata); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) begin pready = 1'b1; prdata = 32'h12345678; end
      n_checks++; if ({psel, penable, pwrite, paddr} !== {3'b110, 8'h08}) $display("FAIL wr_access_%0d: got %h exp 608", k, {psel, penable, pwrite, paddr}); else n_pass++;
    end
    step();
    prdata = 32'h0;
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) $display("FAIL wr_rsp_flags: got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h12345678) $display("FAIL wr_rsp_rdata: got %h exp 12345678", rsp_rdata); else n_pass++;
    step();
  endtask

  task automatic test_slverr();
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFFFFFF;
    issue(1'b0, 8'h0C, 32'h0);
    step(); step();
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) $display("FAIL se_flags: got %b exp 110", {rsp_valid, rsp_err, rsp_timeout}); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL se_rdata: got %h exp 0", rsp_rdata); else n_pass++;
    pslverr = 1'b0; prdata = 32'h0;
    step();
  endtask

  task automatic test_timeout();
    int n_acc;
    n_acc = 0;
    pready = 1'b0;
    issue(1'b1, 8'h10, 32'hA5A5_A5A5);
    for (int k = 0; k < 20 && !rsp_valid; k++) begin
      step();
      if (penable) n_acc++;
    end
    n_checks++; if (n_acc !== 4) $display("FAIL to_access_cycles: got %0d exp 4", n_acc); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout, psel, penable} !== 5'b11100) $display("FAIL to_flags: got %b exp 11100", {rsp_valid, rsp_err, rsp_timeout, psel, penable}); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL to_rdata: got %h exp 0", rsp_rdata); else n_pass++;
    pready = 1'b1;
    step();
  endtask

  task automatic test_backpressure();
    pready = 1'b1; prdata = 32'h0000_00AA; rsp_ready = 1'b0;
    issue(1'b0, 8'h14, 32'h0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h18;
    step(); step();
    prdata = 32'h7777_7777;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if ({rsp_valid, rsp_err, rsp_timeout, cmd_ready, psel} !== 5'b10000) $display("FAIL bp_hold_flags_%0d: got %b exp 10000", k, {rsp_valid, rsp_err, rsp_timeout, cmd_ready, psel}); else n_pass++;
      n_checks++; if ({rsp_rdata, paddr} !== {32'h0000_00AA, 8'h14}) $display("FAIL bp_hold_data_%0d: got %h exp 000000aa14", k, {rsp_rdata, paddr}); else n_pass++;
      step();
    end
    rsp_ready = 1'b1;
    step();
    n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL bp_release: got %b exp 01", {rsp_valid, cmd_ready}); else n_pass++;
    step();
    cmd_valid = 1'b0;
    n_checks++; if ({psel, penable, paddr} !== {2'b10, 8'h18}) $display("FAIL bp_next_accept: got %h exp 218", {psel, penable, paddr}); else n_pass++;
    prdata = 32'h0000_0055;
    step(); step();
    n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_0055}) $display("FAIL bp_next_rsp: got %h exp 100000055", {rsp_valid, rsp_rdata}); else n_pass++;
    prdata = 32'h0;
    step();
  endtask

  task automatic test_back_to_back();
    pready = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'h0000_0030;
    step();
    cmd_addr = 8'h34; cmd_wdata = 32'h0000_0034;
    step(); step(); step();
    n_checks++; if ({cmd_ready, psel} !== 2'b10) $display("FAIL b2b_idle_slot: got %b exp 10", {cmd_ready, psel}); else n_pass++;
    step();
    cmd_valid = 1'b0;
    n_checks++; if ({psel, penable, paddr, pwdata} !== {2'b10, 8'h34, 32'h0000_0034}) $display("FAIL b2b_second_setup: got %h exp 23400000034", {psel, penable, paddr, pwdata}); else n_pass++;
    step(); step(); step();
  endtask

  task automatic test_reset_mid();
    int n_acc;
    pready = 1'b0;
    issue(1'b1, 8'h20, 32'h2020_2020);
    step(); step(); step();
    rst = 1'b1;
    step();
    n_checks++; if ({psel, penable, rsp_valid} !== 3'b000) $display("FAIL rm_outputs: got %b exp 000", {psel, penable, rsp_valid}); else n_pass++;
    rst = 1'b0;
    step();
    n_checks++; if ({cmd_ready, rsp_valid, paddr} !== {2'b10, 8'h00}) $display("FAIL rm_idle: got %h exp 200", {cmd_ready, rsp_valid, paddr}); else n_pass++;
    // watchdog must have restarted from zero: a fresh stall still gets four ACCESS cycles
    n_acc = 0;
    issue(1'b0, 8'h24, 32'h0);
    for (int k = 0; k < 20 && !rsp_valid; k++) begin
      step();
      if (penable) n_acc++;
    end
    n_checks++; if ({n_acc[3:0], rsp_timeout} !== {4'd4, 1'b1}) $display("FAIL rm_wd_cleared: got cycles=%0d timeout=%b exp 4/1", n_acc, rsp_timeout); else n_pass++;
    pready = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; prdata = '0; pready = 1'b1; pslverr = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
